// File: rtl/lea_lcd_pkg.sv
// lea_lcd_pkg: shared constants for the LCD line-2 page scheduler.
package lea_lcd_pkg;
    localparam int LCD_CHARS = 16;
    localparam int LINE_W = 128;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;
    localparam logic [LINE_W-1:0] BLANK_LINE = {LCD_CHARS{ASCII_SPACE}};
endpackage

// File: rtl/lcd_rr_arbiter.sv
// lcd_rr_arbiter: rotate-priority picker; the first set request after last wins.
module lcd_rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      winner,
    output logic            any
);
    logic [1:0] idx;
    always_comb begin
        winner = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % NREQ);
            winner = req[idx] ? idx : winner;
        end
    end
    assign any = |req;
endmodule

// File: rtl/lcd_page_scheduler.sv
// lcd_page_scheduler: round-robin owner of LCD line 2; each granted page is
// latched and held for at least DWELL cycles before the next grant.
module lcd_page_scheduler
    import lea_lcd_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DWELL = 2048,
    parameter int CNT_W = 12
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic [NREQ-1:0]        REQ,
    input  logic [NREQ*LINE_W-1:0] REQ_DATA,
    input  logic                   HOLD,
    input  logic                   CLEAR,
    output logic [NREQ-1:0]        ACK,
    output logic [LINE_W-1:0]      LINE2_DATA,
    output logic [1:0]             PAGE_ID,
    output logic                   PAGE_VALID,
    output logic                   UPDATE
);
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last;
    logic [1:0]       winner;
    logic             any;
    logic             dwellDone;
    logic             grant;

    lcd_rr_arbiter #(.NREQ(NREQ)) arb (
        .req(REQ),
        .last(last),
        .winner(winner),
        .any(any)
    );

    assign dwellDone = state == ST_SHOW && cnt == CNT_W'(DWELL - 1) && !HOLD;
    assign grant = (state == ST_IDLE || dwellDone) && any && !CLEAR;

    // RESETN is active-high here, matching the rest of the LCD datapath.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state <= ST_IDLE;
            cnt <= '0;
            last <= 2'(NREQ - 1);
            ACK <= '0;
            UPDATE <= 1'b0;
            LINE2_DATA <= BLANK_LINE;
            PAGE_ID <= '0;
            PAGE_VALID <= 1'b0;
        end else begin
            ACK <= '0;
            UPDATE <= 1'b0;
            if (CLEAR) begin
                LINE2_DATA <= BLANK_LINE;
                PAGE_VALID <= 1'b0;
                PAGE_ID <= '0;
                state <= ST_IDLE;
                cnt <= '0;
                UPDATE <= PAGE_VALID;
            end else if (grant) begin
                LINE2_DATA <= REQ_DATA[int'(winner)*LINE_W +: LINE_W];
                PAGE_ID <= winner;
                PAGE_VALID <= 1'b1;
                ACK <= NREQ'(1) << winner;
                UPDATE <= 1'b1;
                last <= winner;
                cnt <= '0;
                state <= ST_SHOW;
            end else if (dwellDone) begin
                state <= ST_IDLE;
                cnt <= '0;
            end else if (state == ST_SHOW && !HOLD) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule
